// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the 16-bit CPU datapath. It replaces the
// single-cycle ControlUnit. Each instruction walks through FETCH, DECODE,
// EXEC and then MEM and/or WB as needed. One memory port is shared between
// instruction fetch (address = PC) and data access (address = ALU result).
// Memory accesses wait on MemReady, and a wait counter sends the FSM to
// FAULT if memory never answers. Retired instructions are counted.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles waiting for MemReady in FETCH or MEM
//   CNT_W           width of RetiredCount_o
//
// Ports
//   Clock_i          rising-edge clock
//   Reset_n_i        synchronous, active-low reset
//   Run_i            start request, only looked at in IDLE
//   Opcode_i         IR[15:12], valid from DECODE onward
//   Zero_i           ALU zero flag, valid in EXEC
//   MemReady_i       memory completes the current read/write this cycle
//   PCWrite_o        PC <= PC+1
//   PCBranch_o       PC <= branch target
//   IRWrite_o        IR <= memory read data
//   InstrOrData_o    memory address select (0 = PC, 1 = ALU result)
//   MemRead_o        memory read request
//   MemWrite_o       memory write request
//   RegDst_o         1 = rd, 0 = rt
//   ALUSrc_o         1 = sign-extended immediate
//   MemToReg_o       1 = write back memory data
//   RegWrite_o       register file write enable
//   ALUOp_o          00 add, 01 sub/compare, 10 funct-decoded
//   Busy_o           executing (not IDLE, HALTED or FAULT)
//   Halted_o         HALT instruction reached
//   Fault_o          memory timeout or illegal opcode
//   RetiredCount_o   retired instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             Clock_i,
    input  logic             Reset_n_i,
    input  logic             Run_i,
    input  logic [3:0]       Opcode_i,
    input  logic             Zero_i,
    input  logic             MemReady_i,
    output logic             PCWrite_o,
    output logic             PCBranch_o,
    output logic             IRWrite_o,
    output logic             InstrOrData_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             RegDst_o,
    output logic             ALUSrc_o,
    output logic             MemToReg_o,
    output logic             RegWrite_o,
    output logic [1:0]       ALUOp_o,
    output logic             Busy_o,
    output logic             Halted_o,
    output logic             Fault_o,
    output logic [CNT_W-1:0] RetiredCount_o
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    logic [2:0]        state_q,      state_d;
    logic [3:0]        opcode_q,     opcode_d;
    logic [WAIT_W-1:0] waitCnt_q,    waitCnt_d;
    logic [CNT_W-1:0]  retiredCnt_q, retiredCnt_d;
    logic              retire;

    // Opcode classes; R-type occupies the whole 00xx quarter of the map
    function automatic logic isRType(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    function automatic logic isAddi(input logic [3:0] op);
        return op == 4'b0100;
    endfunction

    function automatic logic isLoad(input logic [3:0] op);
        return op == 4'b1000;
    endfunction

    function automatic logic isStore(input logic [3:0] op);
        return op == 4'b1100;
    endfunction

    function automatic logic isBeq(input logic [3:0] op);
        return op == 4'b1110;
    endfunction

    function automatic logic isHalt(input logic [3:0] op);
        return op == 4'b1111;
    endfunction

    // Next-state logic. The wait counter is cleared whenever FETCH or MEM is
    // entered and only advances while memory stalls. A ready on the last
    // allowed cycle still completes normally because MemReady is tested first.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        waitCnt_d    = waitCnt_q;
        retire       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Run_i) begin
                    state_d   = S_FETCH;
                    waitCnt_d = '0;
                end
            end
            S_FETCH: begin
                if (MemReady_i) begin
                    state_d = S_DECODE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                opcode_d = Opcode_i;
                if (isHalt(Opcode_i)) begin
                    state_d = S_HALTED;
                end else if (isRType(Opcode_i) || isAddi(Opcode_i) || isLoad(Opcode_i) ||
                             isStore(Opcode_i) || isBeq(Opcode_i)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                if (isRType(opcode_q) || isAddi(opcode_q)) begin
                    state_d = S_WB;
                end else if (isLoad(opcode_q) || isStore(opcode_q)) begin
                    state_d   = S_MEM;
                    waitCnt_d = '0;
                end else if (isBeq(opcode_q)) begin
                    state_d   = S_FETCH;
                    waitCnt_d = '0;
                    retire    = 1'b1;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_MEM: begin
                if (MemReady_i) begin
                    if (isLoad(opcode_q)) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        waitCnt_d = '0;
                        retire    = 1'b1;
                    end
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                waitCnt_d = '0;
                retire    = 1'b1;
            end
            default: begin
                state_d = state_q;
            end
        endcase
        retiredCnt_d = retire ? retiredCnt_q + CNT_W'(1) : retiredCnt_q;
    end

    // State registers; reset wins over any retire happening on the same edge
    always_ff @(posedge Clock_i) begin
        if (!Reset_n_i) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            waitCnt_q    <= '0;
            retiredCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            waitCnt_q    <= waitCnt_d;
            retiredCnt_q <= retiredCnt_d;
        end
    end

    // Control decode from registered state and latched opcode. Only the
    // fetch strobes and the branch strobe look at live inputs.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCBranch_o    = 1'b0;
        IRWrite_o     = 1'b0;
        InstrOrData_o = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        RegDst_o      = 1'b0;
        ALUSrc_o      = 1'b0;
        MemToReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        ALUOp_o       = 2'b00;
        Busy_o        = 1'b1;
        Halted_o      = 1'b0;
        Fault_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                Busy_o = 1'b0;
            end
            S_FETCH: begin
                MemRead_o = 1'b1;
                IRWrite_o = MemReady_i;
                PCWrite_o = MemReady_i;
            end
            S_DECODE: begin
                Busy_o = 1'b1;
            end
            S_EXEC: begin
                if (isRType(opcode_q)) begin
                    ALUOp_o = 2'b10;
                end else if (isAddi(opcode_q) || isLoad(opcode_q) || isStore(opcode_q)) begin
                    ALUSrc_o = 1'b1;
                end else if (isBeq(opcode_q)) begin
                    ALUOp_o    = 2'b01;
                    PCBranch_o = Zero_i;
                end
            end
            S_MEM: begin
                InstrOrData_o = 1'b1;
                MemRead_o     = isLoad(opcode_q);
                MemWrite_o    = isStore(opcode_q);
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = isRType(opcode_q);
                MemToReg_o = isLoad(opcode_q);
            end
            S_HALTED: begin
                Busy_o   = 1'b0;
                Halted_o = 1'b1;
            end
            S_FAULT: begin
                Busy_o  = 1'b0;
                Fault_o = 1'b1;
            end
            default: begin
                Busy_o = 1'b0;
            end
        endcase
    end

    assign RetiredCount_o = retiredCnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed bench for the multi-cycle sequencer. All control outputs are
// packed into one 15-bit word so each cycle can be compared against a
// hand-built expected word made from the single-bit masks below. A second
// instance with a 2-bit retire counter exercises counter wrap-around.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    // Packed control word bit masks:
    // {PCWrite, PCBranch, IRWrite, InstrOrData, MemRead, MemWrite, RegDst,
    //  ALUSrc, MemToReg, RegWrite, ALUOp[1:0], Busy, Halted, Fault}
    localparam logic [14:0] PCW   = 15'h4000;
    localparam logic [14:0] PCB   = 15'h2000;
    localparam logic [14:0] IRW   = 15'h1000;
    localparam logic [14:0] IOD   = 15'h0800;
    localparam logic [14:0] MRD   = 15'h0400;
    localparam logic [14:0] MWR   = 15'h0200;
    localparam logic [14:0] RDST  = 15'h0100;
    localparam logic [14:0] ASRC  = 15'h0080;
    localparam logic [14:0] M2R   = 15'h0040;
    localparam logic [14:0] RW    = 15'h0020;
    localparam logic [14:0] OPFN  = 15'h0010;
    localparam logic [14:0] OPSUB = 15'h0008;
    localparam logic [14:0] BUSY  = 15'h0004;
    localparam logic [14:0] HALT  = 15'h0002;
    localparam logic [14:0] FLT   = 15'h0001;

    localparam logic [14:0] C_FETCH_WAIT = MRD | BUSY;
    localparam logic [14:0] C_FETCH_RDY  = PCW | IRW | MRD | BUSY;
    localparam logic [14:0] C_DECODE     = BUSY;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1100;
    localparam logic [3:0] OP_BEQ  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [3:0] OP_ILL  = 4'b1010;

    logic        clock = 1'b0;
    logic        resetN;
    logic        run;
    logic [3:0]  opcode;
    logic        zero;
    logic        memReady;

    logic        pcWrite, pcBranch, irWrite, instrOrData, memRead, memWrite;
    logic        regDst, aluSrc, memToReg, regWrite, busy, halted, fault;
    logic [1:0]  aluOp;
    logic [15:0] retiredCount;
    logic [14:0] ctrl;

    logic        sPcWrite, sPcBranch, sIrWrite, sInstrOrData, sMemRead, sMemWrite;
    logic        sRegDst, sAluSrc, sMemToReg, sRegWrite, sBusy, sHalted, sFault;
    logic [1:0]  sAluOp;
    logic [1:0]  sRetiredCount;
    logic [14:0] sCtrl;

    int vectors     = 0;
    int miscompares = 0;

    assign ctrl  = {pcWrite, pcBranch, irWrite, instrOrData, memRead, memWrite, regDst,
                    aluSrc, memToReg, regWrite, aluOp, busy, halted, fault};
    assign sCtrl = {sPcWrite, sPcBranch, sIrWrite, sInstrOrData, sMemRead, sMemWrite, sRegDst,
                    sAluSrc, sMemToReg, sRegWrite, sAluOp, sBusy, sHalted, sFault};

    multicycle_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .Clock_i(clock), .Reset_n_i(resetN), .Run_i(run), .Opcode_i(opcode),
        .Zero_i(zero), .MemReady_i(memReady),
        .PCWrite_o(pcWrite), .PCBranch_o(pcBranch), .IRWrite_o(irWrite),
        .InstrOrData_o(instrOrData), .MemRead_o(memRead), .MemWrite_o(memWrite),
        .RegDst_o(regDst), .ALUSrc_o(aluSrc), .MemToReg_o(memToReg),
        .RegWrite_o(regWrite), .ALUOp_o(aluOp), .Busy_o(busy), .Halted_o(halted),
        .Fault_o(fault), .RetiredCount_o(retiredCount)
    );

    multicycle_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(2)) dutSmall (
        .Clock_i(clock), .Reset_n_i(resetN), .Run_i(run), .Opcode_i(opcode),
        .Zero_i(zero), .MemReady_i(memReady),
        .PCWrite_o(sPcWrite), .PCBranch_o(sPcBranch), .IRWrite_o(sIrWrite),
        .InstrOrData_o(sInstrOrData), .MemRead_o(sMemRead), .MemWrite_o(sMemWrite),
        .RegDst_o(sRegDst), .ALUSrc_o(sAluSrc), .MemToReg_o(sMemToReg),
        .RegWrite_o(sRegWrite), .ALUOp_o(sAluOp), .Busy_o(sBusy), .Halted_o(sHalted),
        .Fault_o(sFault), .RetiredCount_o(sRetiredCount)
    );

    always #5 clock = ~clock;

    // Move one cycle forward and settle just after the edge
    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    // Reset both instances and start them; returns in the first FETCH cycle
    task automatic doReset();
        resetN   = 1'b0;
        run      = 1'b0;
        memReady = 1'b0;
        zero     = 1'b0;
        opcode   = OP_R;
        advance();
        resetN = 1'b1;
        run    = 1'b1;
        advance();
        run = 1'b0;
    endtask

    task automatic test_reset();
        resetN   = 1'b0;
        run      = 1'b1;
        memReady = 1'b1;
        zero     = 1'b0;
        opcode   = OP_R;
        advance();
        advance();
        vectors++;
        if (ctrl !== 15'h0000) begin
            $display("[TB] FAIL reset_ctrl: got 0x%h expected 0x%h", ctrl, 15'h0000);
            miscompares++;
        end
        vectors++;
        if (retiredCount !== 16'd0) begin
            $display("[TB] FAIL reset_count: got %0d expected 0", retiredCount);
            miscompares++;
        end
        resetN = 1'b1;
        run    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            vectors++;
            if (ctrl !== 15'h0000) begin
                $display("[TB] FAIL idle_hold[%0d]: got 0x%h expected 0x%h", i, ctrl, 15'h0000);
                miscompares++;
            end
        end
        run      = 1'b1;
        memReady = 1'b0;
        advance();
        run = 1'b0;
        vectors++;
        if (ctrl !== C_FETCH_WAIT) begin
            $display("[TB] FAIL reset_to_fetch: got 0x%h expected 0x%h", ctrl, C_FETCH_WAIT);
            miscompares++;
        end
    endtask

    task automatic test_rtype_addi();
        logic [14:0] expR [4];
        logic [14:0] expA [4];
        expR = '{C_FETCH_RDY, C_DECODE, OPFN | BUSY, RW | RDST | BUSY};
        expA = '{C_FETCH_RDY, C_DECODE, ASRC | BUSY, RW | BUSY};
        doReset();
        opcode   = OP_R;
        memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (ctrl !== expR[i]) begin
                $display("[TB] FAIL rtype[%0d]: got 0x%h expected 0x%h", i, ctrl, expR[i]);
                miscompares++;
            end
            advance();
        end
        vectors++;
        if (retiredCount !== 16'd1) begin
            $display("[TB] FAIL rtype_count: got %0d expected 1", retiredCount);
            miscompares++;
        end
        opcode = OP_ADDI;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (ctrl !== expA[i]) begin
                $display("[TB] FAIL addi[%0d]: got 0x%h expected 0x%h", i, ctrl, expA[i]);
                miscompares++;
            end
            advance();
        end
        vectors++;
        if (retiredCount !== 16'd2) begin
            $display("[TB] FAIL addi_count: got %0d expected 2", retiredCount);
            miscompares++;
        end
    endtask

    task automatic test_load_store();
        logic [14:0] expL [8];
        logic        rdyL [8];
        logic [14:0] expS [6];
        logic        rdyS [6];
        expL = '{C_FETCH_RDY, C_DECODE, ASRC | BUSY, IOD | MRD | BUSY, IOD | MRD | BUSY,
                 IOD | MRD | BUSY, IOD | MRD | BUSY, RW | M2R | BUSY};
        rdyL = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        expS = '{C_FETCH_WAIT, C_FETCH_RDY, C_DECODE, ASRC | BUSY, IOD | MWR | BUSY,
                 IOD | MWR | BUSY};
        rdyS = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        doReset();
        opcode = OP_LW;
        for (int i = 0; i < 8; i++) begin
            memReady = rdyL[i];
            #1;
            vectors++;
            if (ctrl !== expL[i]) begin
                $display("[TB] FAIL lw[%0d]: got 0x%h expected 0x%h", i, ctrl, expL[i]);
                miscompares++;
            end
            advance();
        end
        memReady = 1'b0;
        #1;
        vectors++;
        if (ctrl !== C_FETCH_WAIT || retiredCount !== 16'd1) begin
            $display("[TB] FAIL lw_done: got ctrl 0x%h count %0d expected ctrl 0x%h count 1",
                     ctrl, retiredCount, C_FETCH_WAIT);
            miscompares++;
        end
        opcode = OP_SW;
        for (int i = 0; i < 6; i++) begin
            memReady = rdyS[i];
            #1;
            vectors++;
            if (ctrl !== expS[i]) begin
                $display("[TB] FAIL sw[%0d]: got 0x%h expected 0x%h", i, ctrl, expS[i]);
                miscompares++;
            end
            advance();
        end
        memReady = 1'b0;
        #1;
        vectors++;
        if (ctrl !== C_FETCH_WAIT || retiredCount !== 16'd2) begin
            $display("[TB] FAIL sw_done: got ctrl 0x%h count %0d expected ctrl 0x%h count 2",
                     ctrl, retiredCount, C_FETCH_WAIT);
            miscompares++;
        end
    endtask

    task automatic test_branch();
        logic [14:0] expT [3];
        logic [14:0] expN [3];
        expT = '{C_FETCH_RDY, C_DECODE, PCB | OPSUB | BUSY};
        expN = '{C_FETCH_RDY, C_DECODE, OPSUB | BUSY};
        doReset();
        opcode   = OP_BEQ;
        memReady = 1'b1;
        zero     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctrl !== expT[i]) begin
                $display("[TB] FAIL beq_taken[%0d]: got 0x%h expected 0x%h", i, ctrl, expT[i]);
                miscompares++;
            end
            advance();
        end
        vectors++;
        if (retiredCount !== 16'd1) begin
            $display("[TB] FAIL beq_taken_count: got %0d expected 1", retiredCount);
            miscompares++;
        end
        zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctrl !== expN[i]) begin
                $display("[TB] FAIL beq_not_taken[%0d]: got 0x%h expected 0x%h", i, ctrl, expN[i]);
                miscompares++;
            end
            advance();
        end
        #1;
        vectors++;
        if (ctrl !== C_FETCH_RDY || retiredCount !== 16'd2) begin
            $display("[TB] FAIL beq_done: got ctrl 0x%h count %0d expected ctrl 0x%h count 2",
                     ctrl, retiredCount, C_FETCH_RDY);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        doReset();
        opcode = OP_R;
        for (int i = 0; i < 16; i++) begin
            memReady = 1'b0;
            #1;
            vectors++;
            if (ctrl !== C_FETCH_WAIT) begin
                $display("[TB] FAIL fetch_wait[%0d]: got 0x%h expected 0x%h", i, ctrl, C_FETCH_WAIT);
                miscompares++;
            end
            advance();
        end
        vectors++;
        if (ctrl !== FLT) begin
            $display("[TB] FAIL fetch_timeout: got 0x%h expected 0x%h", ctrl, FLT);
            miscompares++;
        end
        memReady = 1'b1;
        run      = 1'b1;
        advance();
        advance();
        run = 1'b0;
        vectors++;
        if (ctrl !== FLT || retiredCount !== 16'd0) begin
            $display("[TB] FAIL fault_absorb: got ctrl 0x%h count %0d expected ctrl 0x%h count 0",
                     ctrl, retiredCount, FLT);
            miscompares++;
        end

        doReset();
        for (int i = 0; i < 15; i++) begin
            advance();
        end
        memReady = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_FETCH_RDY) begin
            $display("[TB] FAIL fetch_last_ready: got 0x%h expected 0x%h", ctrl, C_FETCH_RDY);
            miscompares++;
        end
        advance();
        vectors++;
        if (ctrl !== C_DECODE) begin
            $display("[TB] FAIL fetch_late_decode: got 0x%h expected 0x%h", ctrl, C_DECODE);
            miscompares++;
        end

        // A slow fetch must not eat into the data access's own wait budget
        doReset();
        opcode = OP_SW;
        for (int i = 0; i < 5; i++) begin
            advance();
        end
        memReady = 1'b1;
        advance();
        advance();
        advance();
        memReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            vectors++;
            if (ctrl !== (IOD | MWR | BUSY)) begin
                $display("[TB] FAIL mem_wait[%0d]: got 0x%h expected 0x%h", i, ctrl, IOD | MWR | BUSY);
                miscompares++;
            end
            advance();
        end
        vectors++;
        if (ctrl !== FLT || retiredCount !== 16'd0) begin
            $display("[TB] FAIL mem_timeout: got ctrl 0x%h count %0d expected ctrl 0x%h count 0",
                     ctrl, retiredCount, FLT);
            miscompares++;
        end
    endtask

    task automatic test_halt_illegal();
        doReset();
        opcode   = OP_R;
        memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            advance();
        end
        opcode = OP_HALT;
        #1;
        vectors++;
        if (ctrl !== C_FETCH_RDY) begin
            $display("[TB] FAIL halt_fetch: got 0x%h expected 0x%h", ctrl, C_FETCH_RDY);
            miscompares++;
        end
        advance();
        advance();
        vectors++;
        if (ctrl !== HALT) begin
            $display("[TB] FAIL halt_state: got 0x%h expected 0x%h", ctrl, HALT);
            miscompares++;
        end
        run = 1'b1;
        advance();
        advance();
        advance();
        run = 1'b0;
        vectors++;
        if (ctrl !== HALT || retiredCount !== 16'd1) begin
            $display("[TB] FAIL halt_absorb: got ctrl 0x%h count %0d expected ctrl 0x%h count 1",
                     ctrl, retiredCount, HALT);
            miscompares++;
        end

        doReset();
        opcode   = OP_ILL;
        memReady = 1'b1;
        advance();
        advance();
        vectors++;
        if (ctrl !== FLT || retiredCount !== 16'd0) begin
            $display("[TB] FAIL illegal: got ctrl 0x%h count %0d expected ctrl 0x%h count 0",
                     ctrl, retiredCount, FLT);
            miscompares++;
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        opcode   = OP_LW;
        memReady = 1'b1;
        advance();
        advance();
        advance();
        memReady = 1'b0;
        resetN   = 1'b0;
        advance();
        resetN = 1'b1;
        vectors++;
        if (ctrl !== 15'h0000) begin
            $display("[TB] FAIL reset_in_mem: got 0x%h expected 0x%h", ctrl, 15'h0000);
            miscompares++;
        end

        doReset();
        opcode   = OP_R;
        memReady = 1'b1;
        advance();
        advance();
        advance();
        vectors++;
        if (ctrl !== (RW | RDST | BUSY)) begin
            $display("[TB] FAIL reset_wb_setup: got 0x%h expected 0x%h", ctrl, RW | RDST | BUSY);
            miscompares++;
        end
        resetN = 1'b0;
        advance();
        resetN = 1'b1;
        vectors++;
        if (retiredCount !== 16'd0 || ctrl !== 15'h0000) begin
            $display("[TB] FAIL reset_in_wb: got ctrl 0x%h count %0d expected ctrl 0x0000 count 0",
                     ctrl, retiredCount);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [1:0] expSmall [5];
        expSmall = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        doReset();
        opcode   = OP_BEQ;
        zero     = 1'b0;
        memReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            advance();
            advance();
            advance();
            vectors++;
            if (sRetiredCount !== expSmall[k] || retiredCount !== 16'(k + 1)) begin
                $display("[TB] FAIL wrap[%0d]: got small %0d wide %0d expected small %0d wide %0d",
                         k, sRetiredCount, retiredCount, expSmall[k], k + 1);
                miscompares++;
            end
        end
        vectors++;
        if (sCtrl !== C_FETCH_RDY) begin
            $display("[TB] FAIL wrap_ctrl: got 0x%h expected 0x%h", sCtrl, C_FETCH_RDY);
            miscompares++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN   = 1'b0;
        run      = 1'b0;
        opcode   = 4'b0000;
        zero     = 1'b0;
        memReady = 1'b0;
        test_reset();
        test_rtype_addi();
        test_load_store();
        test_branch();
        test_timeout();
        test_halt_illegal();
        test_mid_reset();
        test_back_to_back_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
